// File: rtl/host_run_ctrl.sv
// Host-side initiator for the core run handshake: loads operands into data memory,
// pulses core reset, issues req, waits for done under a timeout and streams results back.
module host_run_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int N_LOAD    = 4,
    parameter int LOAD_BASE = 0,
    parameter int N_RES     = 2,
    parameter int RES_BASE  = 64,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op_valid,
    input  logic [DW-1:0] op_data,
    output logic          op_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          busy,
    output logic          run_done,
    output logic          timeout_err,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CRST,
        S_REQ,
        S_RUN,
        S_READ,
        S_ERR
    } state_t;

    localparam logic [AW-1:0] LOAD_LAST   = AW'(N_LOAD - 1);
    localparam logic [AW-1:0] RES_LAST    = AW'(N_RES - 1);
    localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
    localparam logic [AW-1:0] CRST_LAST   = AW'(1);
    localparam logic [CW-1:0] TIMEOUT_C   = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic [CW-1:0] count_inc;
    logic          timeout_err_q, timeout_err_d;
    logic          run_done_q, run_done_d;

    assign count_inc = cycle_count_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cycle_count_q <= '0;
            timeout_err_q <= 1'b0;
            run_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cycle_count_q <= cycle_count_d;
            timeout_err_q <= timeout_err_d;
            run_done_q    <= run_done_d;
        end
    end

    // idx is shared: operand index in LOAD, reset-pulse length in CRST, result index in READ.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cycle_count_d = cycle_count_q;
        timeout_err_d = timeout_err_q;
        run_done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cycle_count_d = '0;
                    timeout_err_d = 1'b0;
                    idx_d         = '0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (op_valid) begin
                    if (idx_q == LOAD_LAST) begin
                        idx_d   = '0;
                        state_d = S_CRST;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_CRST: begin
                if (idx_q == CRST_LAST) begin
                    idx_d   = '0;
                    state_d = S_REQ;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_REQ: begin
                state_d = S_RUN;
            end
            // A done arriving on the timeout cycle still counts as a normal finish.
            S_RUN: begin
                cycle_count_d = count_inc;
                if (core_done) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else if (count_inc == TIMEOUT_C) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_READ: begin
                if (idx_q == RES_LAST) begin
                    idx_d      = '0;
                    run_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The memory port belongs to the core except while operands are being loaded.
    always_comb begin
        op_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        core_reset  = 1'b0;
        core_req    = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                core_reset = 1'b1;
            end
            S_LOAD: begin
                op_ready = 1'b1;
                mem_addr = LOAD_BASE_A + idx_q;
                if (op_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = op_data;
                end
            end
            S_CRST: begin
                core_reset = 1'b1;
            end
            S_REQ: begin
                core_req = 1'b1;
            end
            S_READ: begin
                mem_addr  = RES_BASE_A + idx_q;
                res_valid = 1'b1;
                res_data  = mem_rd_data;
            end
            S_ERR: begin
                core_reset = 1'b1;
            end
            default: begin
                core_reset = 1'b0;
            end
        endcase
    end

    assign run_done    = run_done_q;
    assign timeout_err = timeout_err_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_host_run_ctrl.sv
// Bench for host_run_ctrl: a directed run table, a mid-run reset sequence and random runs,
// with a small memory/core model and run-level expectations derived from the handshake rules.
module tb_host_run_ctrl;

    localparam int DW        = 8;
    localparam int AW        = 8;
    localparam int N_LOAD    = 4;
    localparam int LOAD_BASE = 0;
    localparam int N_RES     = 2;
    localparam int RES_BASE  = 64;
    localparam int TIMEOUT   = 16;
    localparam int CW        = 16;
    localparam int MAX_CYC   = 200;

    typedef struct {
        logic [31:0] ops;
        int          gap_len;
        logic [7:0]  gap;
        int          delay;
        logic [7:0]  res0;
        logic [7:0]  res1;
        bit          spurious;
        int          exp_count;
        bit          exp_to;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op_valid;
    logic [DW-1:0] op_data;
    logic          op_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          busy;
    logic          run_done;
    logic          timeout_err;
    logic [CW-1:0] cycle_count;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;
    int cur_row  = 0;

    int obs_writes, obs_bad_writes, obs_crst, obs_req, obs_req_rst, obs_err_rst;
    int obs_clear_bad, obs_res_n, obs_done, obs_count, obs_timeout, obs_ended;
    int last_res, done_cyc;
    logic [7:0] res_got [2];

    vec_t vecs [6];

    host_run_ctrl #(
        .DW(DW), .AW(AW), .N_LOAD(N_LOAD), .LOAD_BASE(LOAD_BASE),
        .N_RES(N_RES), .RES_BASE(RES_BASE), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op_valid(op_valid),
        .op_data(op_data),
        .op_ready(op_ready),
        .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .core_reset(core_reset),
        .core_req(core_req),
        .core_done(core_done),
        .res_valid(res_valid),
        .res_data(res_data),
        .busy(busy),
        .run_done(run_done),
        .timeout_err(timeout_err),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    task automatic checkEq(input string name, input int got, input int expected);
        checks++;
        if (got != expected) begin
            failures++;
            $display("[TB] FAIL row %0d %s: got 0x%0h expected 0x%0h", cur_row, name, got, expected);
        end
    endtask

    // A run is judged only by what a host and core would observe: the run ends
    // normally when done arrives within TIMEOUT RUN cycles, otherwise it times out.
    function automatic vec_t modelRun(input vec_t v);
        vec_t r;
        r           = v;
        r.exp_to    = (v.delay == 0) || (v.delay > TIMEOUT);
        r.exp_count = r.exp_to ? TIMEOUT : v.delay;
        return r;
    endfunction

    // Drives one run (start, operands, core done) and records what the DUT does.
    task automatic applyStimulus(input vec_t v);
        int  op_i;
        int  load_k;
        int  req_cyc;
        int  crst_run;
        bit  ended;
        obs_writes     = 0;
        obs_bad_writes = 0;
        obs_crst       = -1;
        obs_req        = 0;
        obs_req_rst    = 0;
        obs_err_rst    = 0;
        obs_clear_bad  = 0;
        obs_res_n      = 0;
        obs_done       = 0;
        last_res       = -1;
        done_cyc       = -1;
        res_got[0]     = 8'h00;
        res_got[1]     = 8'h00;
        mem[RES_BASE]     = 8'hEE;
        mem[RES_BASE + 1] = 8'hEE;
        op_i     = 0;
        load_k   = 0;
        req_cyc  = -1;
        crst_run = 0;
        ended    = 1'b0;
        for (int cyc = 0; cyc < MAX_CYC && !ended; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (v.spurious && req_cyc >= 0 && cyc == req_cyc + 2);
            core_done = 1'b0;
            if (v.delay > 0 && req_cyc >= 0 && cyc == req_cyc + v.delay) begin
                core_done         = 1'b1;
                mem[RES_BASE]     = v.res0;
                mem[RES_BASE + 1] = v.res1;
            end
            if (v.spurious && cyc == 1) core_done = 1'b1;
            if (cyc >= 1 && op_i < N_LOAD) begin
                op_valid = (load_k < v.gap_len) ? v.gap[load_k] : 1'b1;
                op_data  = v.ops[8*op_i +: 8];
                load_k++;
            end else begin
                op_valid = 1'b1;
                op_data  = 8'h99;
            end
            #1;
            if (mem_wr_en) begin
                if (op_valid && op_ready && cyc >= 1 && op_i < N_LOAD &&
                    mem_addr == 8'(LOAD_BASE + op_i) && mem_wr_data == v.ops[8*op_i +: 8])
                    obs_writes++;
                else
                    obs_bad_writes++;
                mem[mem_addr] = mem_wr_data;
            end
            if (op_valid && op_ready && cyc >= 1 && op_i < N_LOAD) op_i++;
            if (cyc == 1 && (timeout_err !== 1'b0 || cycle_count !== '0)) obs_clear_bad++;
            if (core_req) begin
                obs_req++;
                if (core_reset) obs_req_rst++;
                if (req_cyc < 0) begin
                    req_cyc  = cyc;
                    obs_crst = crst_run;
                end
            end
            if (busy && core_reset) begin
                crst_run++;
                if (req_cyc >= 0) obs_err_rst++;
            end else begin
                crst_run = 0;
            end
            if (res_valid) begin
                if (obs_res_n < 2) res_got[obs_res_n] = res_data;
                obs_res_n++;
                last_res = cyc;
            end
            if (run_done) begin
                obs_done++;
                done_cyc = cyc;
            end
            if (cyc > 0 && !busy) ended = 1'b1;
        end
        obs_ended   = ended ? 1 : 0;
        obs_count   = 32'(cycle_count);
        obs_timeout = 32'(timeout_err);
        start     = 1'b0;
        core_done = 1'b0;
        op_valid  = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        cur_row = row;
        checkEq("run ended", obs_ended, 1);
        checkEq("operand writes", obs_writes, N_LOAD);
        checkEq("stray writes", obs_bad_writes, 0);
        checkEq("core_reset cycles before req", obs_crst, 2);
        checkEq("req pulses", obs_req, 1);
        checkEq("core_reset during req", obs_req_rst, 0);
        checkEq("err reset cycles", obs_err_rst, v.exp_to ? 1 : 0);
        checkEq("start clears status", obs_clear_bad, 0);
        checkEq("cycle_count", obs_count, v.exp_count);
        checkEq("timeout_err", obs_timeout, v.exp_to ? 1 : 0);
        checkEq("result beats", obs_res_n, v.exp_to ? 0 : N_RES);
        checkEq("run_done pulses", obs_done, v.exp_to ? 0 : 1);
        if (!v.exp_to) begin
            checkEq("result byte 0", 32'(res_got[0]), 32'(v.res0));
            checkEq("result byte 1", 32'(res_got[1]), 32'(v.res1));
            checkEq("run_done after last result", done_cyc, last_res + 1);
        end
    endtask

    // Reset is raised mid-cycle while the core is running; the block must drop to idle at once.
    task automatic resetMidRun();
        bit req_seen;
        cur_row  = 100;
        req_seen = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        op_valid  = 1'b1;
        op_data   = 8'h5C;
        core_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !req_seen; i++) begin
            @(negedge clk);
            #1;
            if (core_req) req_seen = 1'b1;
        end
        checkEq("reached req", req_seen ? 1 : 0, 1);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkEq("busy in run", 32'(busy), 1);
        checkEq("core_req low in run", 32'(core_req), 0);
        checkEq("cycle_count mid run", 32'(cycle_count), 4);
        #2;
        reset = 1'b1;
        #1;
        checkEq("async reset busy", 32'(busy), 0);
        checkEq("async reset core_reset", 32'(core_reset), 1);
        checkEq("async reset cycle_count", 32'(cycle_count), 0);
        checkEq("async reset other outputs",
                32'({op_ready, mem_wr_en, core_req, res_valid, run_done, timeout_err}), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        reset     = 1'b1;
        start     = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        core_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //          ops           gap_len gap    delay res0   res1   spur  count to
        vecs[0] = '{32'h44332211, 0,      8'h00, 10,   8'hA5, 8'h5A, 1'b0, 10,   1'b0};
        vecs[1] = '{32'hEFBEADDE, 7,      8'h59, 3,    8'h01, 8'h02, 1'b0, 3,    1'b0};
        vecs[2] = '{32'h04030201, 0,      8'h00, 0,    8'h77, 8'h88, 1'b0, 16,   1'b1};
        vecs[3] = '{32'h0D0C0B0A, 0,      8'h00, 16,   8'hC3, 8'h3C, 1'b0, 16,   1'b0};
        vecs[4] = '{32'h55AA55AA, 2,      8'h02, 12,   8'h9F, 8'hF9, 1'b1, 12,   1'b0};
        vecs[5] = '{32'h00FF00FF, 0,      8'h00, 1,    8'h00, 8'hFF, 1'b0, 1,    1'b0};

        repeat (2) @(negedge clk);
        #1;
        cur_row = -1;
        checkEq("reset busy", 32'(busy), 0);
        checkEq("reset core_reset", 32'(core_reset), 1);
        checkEq("reset cycle_count", 32'(cycle_count), 0);
        checkEq("reset other outputs",
                32'({op_ready, mem_wr_en, core_req, res_valid, run_done, timeout_err}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 6; r++) begin
            applyStimulus(vecs[r]);
            checkOutput(vecs[r], r);
        end

        resetMidRun();

        for (int k = 0; k < 10; k++) begin
            v.ops      = $urandom;
            v.gap_len  = $urandom_range(0, 8);
            v.gap      = 8'($urandom);
            v.delay    = $urandom_range(0, 20);
            v.res0     = 8'($urandom);
            v.res1     = 8'($urandom);
            v.spurious = 1'($urandom_range(0, 1));
            v          = modelRun(v);
            applyStimulus(v);
            checkOutput(v, 200 + k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_run_ctrl.md
Name: host_run_ctrl

Overview:
- Host-side initiator for the processor core's req/done run handshake.
- Streams operand bytes into core data memory over the shared memory write port, pulses core reset, then issues req.
- Waits for done with a cycle counter and timeout, then reads result bytes back from data memory and presents them as a result stream.
- Sits between the testbench/host interface and the core's reset/req/done pins plus the data-memory host port.

Parameters:
- DW, 8, data-memory word width.
- AW, 8, data-memory address width.
- N_LOAD, 4, number of operand bytes loaded per run (1..2^AW).
- LOAD_BASE, 0, data-memory address of the first operand byte.
- N_RES, 2, number of result bytes read back per run (1..2^AW).
- RES_BASE, 64, data-memory address of the first result byte.
- TIMEOUT, 4096, maximum number of RUN cycles allowed before an error.
- CW, 16, cycle-counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, begin a run; sampled only in IDLE.
- op_valid, input, 1, operand byte valid.
- op_data, input, DW, operand byte.
- op_ready, output, 1, operand accepted this cycle when op_valid is also high.
- mem_wr_en, output, 1, data-memory write enable.
- mem_addr, output, AW, data-memory address for both write and read.
- mem_wr_data, output, DW, data-memory write data.
- mem_rd_data, input, DW, data-memory read data; combinational read of mem_addr.
- core_reset, output, 1, reset to the processor core.
- core_req, output, 1, run request to the core.
- core_done, input, 1, core completion flag.
- res_valid, output, 1, res_data valid; no backpressure.
- res_data, output, DW, result byte.
- busy, output, 1, high in every state except IDLE.
- run_done, output, 1, one-cycle pulse when a run finishes normally.
- timeout_err, output, 1, sticky timeout flag; cleared on the next accepted start.
- cycle_count, output, CW, RUN-cycle count of the last or current run.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE, idx = 0.
  - cycle_count = 0, timeout_err = 0.
  - core_reset = 1.
  - All other outputs 0.
- States: IDLE, LOAD, CRST, REQ, RUN, READ, ERR.
- IDLE:
  - core_reset = 1.
  - start=1: clear cycle_count, clear timeout_err, set idx = 0, go to LOAD.
- LOAD:
  - op_ready = 1.
  - On op_valid & op_ready: mem_wr_en = 1, mem_addr = LOAD_BASE + idx (mod 2^AW), mem_wr_data = op_data, idx++.
  - After the N_LOAD-th accepted byte: go to CRST with idx = 0.
  - When op_valid = 0: no write, state holds.
- CRST:
  - core_reset = 1 for exactly 2 cycles, then go to REQ.
- REQ:
  - core_reset = 0, core_req = 1 for exactly 1 cycle, then go to RUN.
- RUN:
  - core_req = 0.
  - cycle_count increments every cycle, starting at 1 in the first RUN cycle.
  - core_done = 1: go to READ (the done cycle is counted).
  - cycle_count == TIMEOUT with done low: go to ERR.
  - core_done high in the same cycle the count reaches TIMEOUT: done wins, go to READ.
- READ:
  - mem_addr = RES_BASE + idx (mod 2^AW).
  - res_valid = 1, res_data = mem_rd_data (same cycle).
  - idx++ each cycle.
  - After N_RES cycles: pulse run_done = 1 for one cycle and go to IDLE.
- ERR:
  - timeout_err = 1, core_reset = 1 for one cycle, then go to IDLE.
- Signals ignored outside their owning state:
  - core_done outside RUN.
  - start outside IDLE (no queuing).
  - op_valid outside LOAD.
- mem_wr_en is high only in LOAD; the core owns the memory port outside LOAD.
- cycle_count holds its value after RUN until the next accepted start.
- Address arithmetic wraps modulo 2^AW.
- Reset asserted mid-run aborts immediately to IDLE; partial loads are not undone.

Test Plan:
- Normal run (N_LOAD=4, N_RES=2, RES_BASE=64): stream 0x11, 0x22, 0x33, 0x44 with op_valid held high; core model raises done 10 cycles after req with mem[64]=0xA5, mem[65]=0x5A.
  - Writes land at addresses 0..3 on 4 consecutive cycles.
  - core_reset is high for 2 cycles, then core_req pulses once.
  - cycle_count = 10.
  - res_valid for 2 cycles with 0xA5 then 0x5A, then a single run_done pulse.
- Operand gaps: op_valid toggles 1,0,0,1,1,0,1.
  - Exactly 4 writes to consecutive addresses; no write on gap cycles.
- Timeout (TIMEOUT=16): core_done is never raised.
  - ERR entered after 16 RUN cycles; timeout_err = 1; no res_valid, no run_done.
  - A new start clears timeout_err.
- Done coincident with timeout: core_done first rises in the 16th RUN cycle (TIMEOUT=16).
  - READ entered; timeout_err stays 0; cycle_count = 16.
- Spurious inputs: start pulsed during RUN, core_done pulsed during LOAD.
  - No state change; the run completes normally.
- Reset during RUN: assert reset asynchronously mid-cycle.
  - Immediately state = IDLE, core_reset = 1, busy = 0, cycle_count = 0, outputs at reset values.
